irq_pending_dispatch: RTL and testbench

//  Sits upstream of the 8:3 priority encoder. Captures rising edges on N request lines into sticky pending bits
//  and masks them. Presents the eligible vector to a priority pick and dispatches the winning index over a

---
 rtl/irq_pending_dispatch_pkg.sv | 14 +
 rtl/irq_prio_pick.sv | 24 ++
 rtl/irq_pending_dispatch.sv | 93 +++++++++
 tb/tb_irq_pending_dispatch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_dispatch_pkg.sv
// Shared types and defaults for the interrupt pending/dispatch block.
// Holds the dispatch FSM state encoding and default widths.
package irq_pending_dispatch_pkg;

  localparam int N_DEF      = 8;
  localparam int LOST_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OFFER  = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational priority pick: highest set request bit wins.
// Ports: req (N) in; idx (IDX_W) out; none out (no bit set).
module irq_prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  always_comb begin
    idx  = '0;
    none = 1'b1;
    // ascending scan, so the last hit is the highest index
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx  = IDX_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_pending_dispatch.sv
// Sticky edge-captured IRQ pending bits, masked priority pick, and a
// valid/ready dispatcher that retires one request per accepted offer.
// Ports: clk, rst (sync high); irq_in, irq_mask (N) in; dsp_valid,
// dsp_idx out, dsp_ready in; pending (N), idle, lost_cnt (LOST_W) out.
module irq_pending_dispatch
  import irq_pending_dispatch_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int LOST_W = LOST_W_DEF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      irq_in,
  input  logic [N-1:0]      irq_mask,
  output logic              dsp_valid,
  output logic [IDX_W-1:0]  dsp_idx,
  input  logic              dsp_ready,
  output logic [N-1:0]      pending,
  output logic              idle,
  output logic [LOST_W-1:0] lost_cnt
);

  state_t           state, state_nxt;
  logic [N-1:0]     irq_q;
  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  logic [N-1:0]     elig;
  logic [IDX_W-1:0] pick;
  logic             none;
  logic [IDX_W-1:0] idx_nxt;
  logic             lost_any;

  assign rise      = irq_in & ~irq_q;
  assign elig      = pending & irq_mask;
  assign dsp_valid = (state == S_OFFER);
  assign clr       = (dsp_valid & dsp_ready) ? (N'(1) << dsp_idx) : '0;
  // a rise on the bit being retired is a fresh request, not a loss
  assign lost_any  = |(rise & pending & ~clr);
  assign idle      = (state == S_IDLE) & none;

  irq_prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (elig),
    .idx  (pick),
    .none (none)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = dsp_idx;
    unique case (state)
      S_IDLE: begin
        if (!none) begin
          idx_nxt   = pick;
          state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (dsp_ready) state_nxt = S_RETIRE;
      end
      S_RETIRE: begin
        if (!none) begin
          idx_nxt   = pick;
          state_nxt = S_OFFER;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dsp_idx  <= '0;
      irq_q    <= '0;
      pending  <= '0;
      lost_cnt <= '0;
    end else begin
      state   <= state_nxt;
      dsp_idx <= idx_nxt;
      irq_q   <= irq_in;
      pending <= (pending & ~clr) | rise;
      if (lost_any && (lost_cnt != '1))
        lost_cnt <= lost_cnt + LOST_W'(1);
    end
  end

endmodule

// File: tb/tb_irq_pending_dispatch.sv
// Directed bench for irq_pending_dispatch: vector table plus
// hand-written multi-cycle sequences.
module tb_irq_pending_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] irq_mask;
  logic       dsp_valid;
  logic [2:0] dsp_idx;
  logic       dsp_ready;
  logic [7:0] pending;
  logic       idle;
  logic [7:0] lost_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_pending_dispatch dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .dsp_valid (dsp_valid),
    .dsp_idx   (dsp_idx),
    .dsp_ready (dsp_ready),
    .pending   (pending),
    .idle      (idle),
    .lost_cnt  (lost_cnt)
  );

  typedef struct {
    logic [7:0] irq;
    logic [7:0] mask;
    logic       rdy;
    logic       e_valid;
    logic [2:0] e_idx;
    logic [7:0] e_pend;
    logic       e_idle;
    logic [7:0] e_lost;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; irq_mask = 8'hFF; dsp_ready = 1'b0;
    tick();
    rst = 1'b0;

    // 1: reset state held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_idle", int'(idle), 1);
      chk("rst_valid", int'(dsp_valid), 0);
      chk("rst_pend", int'(pending), 0);
      chk("rst_lost", int'(lost_cnt), 0);
    end

    // 2: two-line dispatch, table driven
    vt[0] = '{8'h24, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h24, 1'b0, 8'h00};
    vt[1] = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h24, 1'b0, 8'h00};
    vt[2] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h04, 1'b0, 8'h00};
    vt[3] = '{8'h00, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h04, 1'b0, 8'h00};
    vt[4] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 8'h00};
    vt[5] = '{8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 8'h00};
    for (int i = 0; i < 6; i++) begin
      irq_in = vt[i].irq; irq_mask = vt[i].mask; dsp_ready = vt[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), int'(dsp_valid), int'(vt[i].e_valid));
      if (vt[i].e_valid || i >= 2)
        chk($sformatf("v%0d_idx", i), int'(dsp_idx), int'(vt[i].e_idx));
      chk($sformatf("v%0d_pend", i), int'(pending), int'(vt[i].e_pend));
      chk($sformatf("v%0d_idle", i), int'(idle), int'(vt[i].e_idle));
      chk($sformatf("v%0d_lost", i), int'(lost_cnt), int'(vt[i].e_lost));
    end

    // 3: offer held stable against mask and new pending
    dsp_ready = 1'b0; irq_in = 8'h08; irq_mask = 8'hFF;
    tick();
    tick();
    chk("s3_offer_valid", int'(dsp_valid), 1);
    chk("s3_offer_idx", int'(dsp_idx), 3);
    irq_in = 8'h88; irq_mask = 8'h00;
    tick();
    tick();
    chk("s3_hold_valid", int'(dsp_valid), 1);
    chk("s3_hold_idx", int'(dsp_idx), 3);
    chk("s3_hold_pend", int'(pending), 8'h88);
    dsp_ready = 1'b1;
    tick();
    chk("s3_acc_pend", int'(pending), 8'h80);
    chk("s3_acc_valid", int'(dsp_valid), 0);
    tick();
    chk("s3_masked_idle", int'(idle), 1);
    chk("s3_masked_pend", int'(pending), 8'h80);
    dsp_ready = 1'b0; irq_in = 8'h00; irq_mask = 8'hFF;
    tick();
    chk("s3_unmask_idx", int'(dsp_idx), 7);
    dsp_ready = 1'b1;
    tick();
    tick();
    chk("s3_drain_idle", int'(idle), 1);

    // 4: lost-request counting and saturation (masked, no dispatch)
    dsp_ready = 1'b0; irq_mask = 8'h00;
    irq_in = 8'h02; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h02; tick();
    chk("s4_pend1", int'(pending[1]), 1);
    chk("s4_lost1", int'(lost_cnt), 1);
    for (int i = 0; i < 300; i++) begin
      irq_in = 8'h00; tick();
      irq_in = 8'h02; tick();
    end
    chk("s4_sat", int'(lost_cnt), 8'hFF);
    irq_in = 8'h00; tick();
    irq_in = 8'h02; tick();
    chk("s4_sat_hold", int'(lost_cnt), 8'hFF);
    irq_in = 8'h00; rst = 1'b1; tick();
    rst = 1'b0;
    chk("s4_rst_lost", int'(lost_cnt), 0);
    // two simultaneous losses count once
    irq_in = 8'h06; tick();
    irq_in = 8'h00; tick();
    irq_in = 8'h06; tick();
    chk("s4_multi_lost", int'(lost_cnt), 1);
    chk("s4_multi_pend", int'(pending), 8'h06);
    irq_in = 8'h00; rst = 1'b1; tick();
    rst = 1'b0;

    // 5: rise on offered line in accept cycle
    irq_mask = 8'hFF; dsp_ready = 1'b0;
    irq_in = 8'h10; tick();
    irq_in = 8'h00; tick();
    chk("s5_offer_idx", int'(dsp_idx), 4);
    dsp_ready = 1'b1; irq_in = 8'h10;
    tick();
    chk("s5_pend_kept", int'(pending), 8'h10);
    chk("s5_lost_same", int'(lost_cnt), 0);
    chk("s5_retire_valid", int'(dsp_valid), 0);
    dsp_ready = 1'b0;
    tick();
    chk("s5_reoffer_valid", int'(dsp_valid), 1);
    chk("s5_reoffer_idx", int'(dsp_idx), 4);
    dsp_ready = 1'b1; irq_in = 8'h00;
    tick();
    tick();
    chk("s5_idle", int'(idle), 1);

    // 6: reset mid-offer, lines held high through reset
    dsp_ready = 1'b0; irq_in = 8'h81;
    tick();
    tick();
    chk("s6_offer", int'(dsp_valid), 1);
    chk("s6_pend", int'(pending), 8'h81);
    rst = 1'b1;
    tick();
    chk("s6_rst_valid", int'(dsp_valid), 0);
    chk("s6_rst_pend", int'(pending), 0);
    chk("s6_rst_idle", int'(idle), 1);
    rst = 1'b0;
    tick();
    chk("s6_rerise_pend", int'(pending), 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
